// File: rtl/mcu_core_gen.sv
// mcu_core_gen: multi-cycle 4-state microcontroller core (IF -> FD -> EX -> RWB)
// for the 16-bit, 16-opcode instruction set, with DW-bit data and PW-bit PC.
// Optional macro MCU_CORE_MULDIV_EN: when defined, MUL and DIV are built;
// when undefined, opcodes 5 and 6 yield 0 (dz=0) and still write RF[RD].
// Handshake: none; imem_data must be stable at the clock edge that leaves IF.
module mcu_core_gen #(
   parameter int DW = 8,
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   output logic [PW-1:0] imem_addr,
   input  logic [15:0]   imem_data,
   output logic [1:0]    state,
   output logic [PW-1:0] pc,
   output logic [3:0]    opcode,
   output logic [DW-1:0] alu_out,
   output logic [DW-1:0] w_reg,
   output logic          cout,
   output logic          of,
   output logic          dz,
   output logic          halted
);

   localparam logic [1:0] S_IF  = 2'b00;
   localparam logic [1:0] S_FD  = 2'b01;
   localparam logic [1:0] S_EX  = 2'b10;
   localparam logic [1:0] S_RWB = 2'b11;

   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_LDI  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_ADI  = 4'h4;
   localparam logic [3:0] OP_MUL  = 4'h5;
   localparam logic [3:0] OP_DIV  = 4'h6;
   localparam logic [3:0] OP_DEC  = 4'h7;
   localparam logic [3:0] OP_INC  = 4'h8;
   localparam logic [3:0] OP_NOR  = 4'h9;
   localparam logic [3:0] OP_NAND = 4'hA;
   localparam logic [3:0] OP_XOR  = 4'hB;
   localparam logic [3:0] OP_COMP = 4'hC;
   localparam logic [3:0] OP_CMPJ = 4'hD;
   localparam logic [3:0] OP_JMP  = 4'hE;
   localparam logic [3:0] OP_HLT  = 4'hF;

   localparam int DW1 = DW + 1;

   logic [15:0]   ir;
   logic [DW-1:0] a, b;
   logic [DW-1:0] rf [16];
   logic [1:0]    next_state;
   logic          load_ir, load_ops, load_res, retire;
   logic [DW-1:0] add_x, add_y, res;
   logic          add_cin, arith, res_dz, res_cout, res_of, writes;
   logic [DW:0]   add_sum;
   logic [PW-1:0] pc_next;

   assign opcode    = ir[15:12];
   assign imem_addr = pc;
   assign alu_out   = res;

   // State register: a halted core sits in IF because next_state never moves.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IF;
      else       state <= next_state;
   end

   // Next-state: advance one phase per enabled edge unless halted.
   always_comb begin
      next_state = state;
      if (en && !halted) begin
         case (state)
            S_IF:    next_state = S_FD;
            S_FD:    next_state = S_EX;
            S_EX:    next_state = S_RWB;
            default: next_state = S_IF;
         endcase
      end
   end

   // FSM outputs: one load strobe per phase, only on an advancing edge.
   always_comb begin
      load_ir  = 1'b0;
      load_ops = 1'b0;
      load_res = 1'b0;
      retire   = 1'b0;
      if (en && !halted) begin
         case (state)
            S_IF:    load_ir  = 1'b1;
            S_FD:    load_ops = 1'b1;
            S_EX:    load_res = 1'b1;
            default: retire   = 1'b1;
         endcase
      end
   end

   // Shared adder operands; subtraction forms are X + ~Y + 1.
   always_comb begin
      add_x   = a;
      add_y   = b;
      add_cin = 1'b0;
      arith   = 1'b0;
      case (opcode)
         OP_ADD: arith = 1'b1;
         OP_SUB: begin add_y = ~b; add_cin = 1'b1; arith = 1'b1; end
         OP_ADI: begin add_y = DW'(ir[7:4]); arith = 1'b1; end
         OP_DEC: begin add_x = b; add_y = ~DW'(1); add_cin = 1'b1; arith = 1'b1; end
         OP_INC: begin add_x = b; add_y = DW'(1); arith = 1'b1; end
         default: ;
      endcase
   end

   assign add_sum  = {1'b0, add_x} + {1'b0, add_y} + DW1'(add_cin);
   assign res_cout = arith & add_sum[DW];
   assign res_of   = arith & (add_x[DW-1] == add_y[DW-1]) & (add_sum[DW-1] != add_x[DW-1]);

   // ALU result selection; divide-by-zero returns all-ones and raises dz.
   always_comb begin
      res    = '0;
      res_dz = 1'b0;
      case (opcode)
         OP_ADD, OP_SUB, OP_ADI, OP_DEC, OP_INC: res = add_sum[DW-1:0];
         OP_LDI:  res = DW'(ir[11:4]);
`ifdef MCU_CORE_MULDIV_EN
         OP_MUL:  res = a * b;
         OP_DIV: begin
            if (b == '0) begin
               res    = '1;
               res_dz = 1'b1;
            end else begin
               res = a / b;
            end
         end
`else
         OP_MUL, OP_DIV: res = '0;
`endif
         OP_NOR:  res = ~(a | b);
         OP_NAND: res = ~(a & b);
         OP_XOR:  res = a ^ b;
         OP_COMP: res = ~b;
         default: res = '0;
      endcase
   end

   assign writes = (opcode >= OP_ADD) && (opcode <= OP_COMP);

   // PC update chosen in RWB; all arithmetic wraps at PW bits.
   always_comb begin
      pc_next = pc + PW'(1);
      case (opcode)
         OP_JMP:  pc_next = PW'(ir[11:4]);
         OP_CMPJ: if (a >= b) pc_next = pc + PW'(ir[3:0]);
         OP_HLT:  pc_next = pc;
         default: ;
      endcase
   end

   // Datapath registers: each loads only on its own phase strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc     <= '0;
         ir     <= '0;
         a      <= '0;
         b      <= '0;
         w_reg  <= '0;
         cout   <= 1'b0;
         of     <= 1'b0;
         dz     <= 1'b0;
         halted <= 1'b0;
         for (int i = 0; i < 16; i++) rf[i] <= '0;
      end else begin
         if (load_ir) ir <= imem_data;
         if (load_ops) begin
            a <= rf[ir[11:8]];
            b <= rf[ir[7:4]];
         end
         if (load_res) begin
            w_reg <= res;
            cout  <= res_cout;
            of    <= res_of;
            dz    <= res_dz;
         end
         if (retire) begin
            pc <= pc_next;
            if (writes) rf[ir[3:0]] <= w_reg;
            if (opcode == OP_HLT) halted <= 1'b1;
         end
      end
   end

endmodule

// File: doc/mcu_core_gen.md
# mcu_core_gen

Parametrised multi-cycle 4-state microcontroller core (IF → FD → EX → RWB) executing the team's 16-bit, 16-opcode instruction set against an external instruction memory port. Generalises the 8-bit lab MCU to configurable data and PC widths. It adds a clock-enable for stepping, a registered instruction latch, sticky halt, and defined divide-by-zero behaviour. It sits between the board wrapper (slow clock / key stepping, seven-segment display) and a program ROM.

## Interface
- DW, 8: datapath and register width (≥ 8).
- PW, 8: PC / instruction-address width (≥ 8).
- clk in 1: clock, rising edge.
- reset in 1: reset, asynchronous, active-high.
- en in 1: advance enable; when low, every register holds.
- imem_addr out PW: instruction address, equal to pc.
- imem_data in 16: instruction word; must be valid by the IF clock edge.
- state out 2: IF=00, FD=01, EX=10, RWB=11.
- pc out PW: program counter.
- opcode out 4: ir[15:12] of the latched instruction.
- alu_out out DW: combinational ALU result from operand registers.
- w_reg out DW: registered result.
- cout out 1: registered carry flag.
- of out 1: registered signed-overflow flag.
- dz out 1: registered divide-by-zero flag.
- halted out 1: sticky halt.

## Operation
- Fields: RA=ir[11:8], RB=ir[7:4], RD=ir[3:0]. 16 registers of DW bits. A=RF[RA], B=RF[RB].
- Reset values: state=IF, pc=0, ir=0, A=B=0, w_reg=0, cout=of=dz=0, halted=0, all RF=0.
- IF: ir ← imem_data. FD: A, B ← RF. EX: w_reg, cout, of, dz ← ALU. RWB: writeback and PC update.
- Opcodes: 0 NOP→0. 1 ADD A+B. 2 LDI zero-ext {RA,RB}. 3 SUB A−B. 4 ADI A+zero-ext RB. 5 MUL low DW bits of A·B. 6 DIV A/B unsigned. 7 DEC B−1. 8 INC B+1. 9 NOR. A NAND. B XOR. C COMP ~B. D CMPJ→0. E JMP→0. F HLT→0.
- Arithmetic is DW bits wide. ADD/ADI/INC: cout = carry out of bit DW−1. SUB/DEC: computed as X+~Y+1, cout = that carry (1 = no borrow). of = standard two's-complement overflow for these five opcodes. cout=of=0 for all other opcodes.
- DIV with B=0: result all-ones and dz=1. Otherwise dz=0.
- RWB write: RF[RD] ← w_reg for opcodes 1–C. Opcodes 0, D, E and F do not write.
- PC in RWB:
  - E: pc ← zero-ext/truncated {RA,RB}.
  - D: pc ← pc+RD if A ≥ B unsigned, else pc+1.
  - F: pc unchanged; halted ← 1.
  - All others: pc+1.
  - All PC arithmetic wraps modulo 2^PW.
- Halted: the FSM goes to IF and freezes. pc, RF, w_reg and flags hold until reset. en is ignored.

## Timing
- One instruction per 4 enabled cycles. state advances only on edges with en=1.
- en=0 at any state: all state, including RF, is frozen. Execution resumes exactly where it stopped.
- Register write and PC update take effect on the RWB→IF edge. The next IF fetches at the new pc.
- A CMPJ/JMP target equal to the current pc loops legally; no special handling.
- reset asserted mid-instruction: all registers go to reset values immediately. The first fetch is at pc=0 on the first enabled edge after deassertion.
- alu_out is combinational from A, B and ir. It is valid in EX; in other states it is don't-care for checking.

## Configuration
- MCU_CORE_MULDIV_EN defined: MUL and DIV are implemented as above.
- Not defined: no multiplier or divider is synthesised. Opcodes 5 and 6 produce result 0 with dz=0, and still write RF[RD].

## Test plan
- LDI r1=0x05, LDI r2=0x03, ADD r1,r2→r3: after 12 enabled cycles RF[3]=0x08, cout=0, of=0, pc=3.
- DW=8: ADD 0x7F+0x01 → w_reg=0x80, of=1, cout=0. SUB 0x00−0x01 → 0xFF, cout=0. INC 0xFF → 0x00, cout=1.
- CMPJ with A=0x0A, B=0x03, RD=6 at pc=4 → pc=10. With A=0x02 → pc=5. JMP 0x40 → pc=0x40.
- DIV by zero with the macro defined → w_reg=0xFF, dz=1, RF[RD]=0xFF. With the macro undefined → 0x00, dz=0.
- en held low for 7 cycles in EX → state, pc and w_reg unchanged. Release → RWB completes normally. HLT at pc=0x14 → halted=1, pc stays 0x14 over 50 cycles.
- reset pulsed during FD of the third instruction → all outputs 0, state=IF. Re-execution from pc=0 reproduces the first test's results.
